snake_sound_seq: RTL and testbench

Game-event sound sequencer for the Snake design. Converts single-cycle game events (start, food eaten, crash) into short fixed melodies. Each melody is a timed series of note divider values presented on `freq_datas` with an `output_beep` enable. Sits directly upstream of `beep`, driving its `freq_datas` and `output_beep` inputs.

---
 rtl/snake_sound_seq.sv | 95 +++++++++
 tb/tb_snake_sound_seq.sv | 94 +++++++++
 2 files changed

// File: rtl/snake_sound_seq.sv
// snake_sound_seq: turns start/eat/crash game events into short registered note melodies for beep
// Ports: sys_clk (50 MHz), sys_rst_n (async, active-low), start_evt/eat_evt/crash_evt (one-cycle events),
//        mute (level, silences output only), freq_datas (note divider, 0 when silent),
//        output_beep (tone enable), busy (melody in progress)
// Build option: SOUND_GAP_EN inserts one silent tick between consecutive notes of a melody
module snake_sound_seq #(
  parameter logic [24:0] TICK_MAX = 25'd2_499_999,
  parameter logic [17:0] DO       = 18'd190839,
  parameter logic [17:0] MI       = 18'd151514,
  parameter logic [17:0] SO       = 18'd127550
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start_evt,
  input  logic        eat_evt,
  input  logic        crash_evt,
  input  logic        mute,
  output logic [17:0] freq_datas,
  output logic        output_beep,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
  localparam logic [1:0] MEL_START = 2'd0, MEL_EAT = 2'd1, MEL_CRASH = 2'd2;
  state_t state;
  logic [1:0] mel, idx, sel, nidx;
  logic [3:0] dur;
  logic [24:0] tick;
  logic go, on;
  function automatic logic [17:0] note_val(input logic [1:0] m, input logic [1:0] i);
    case (m)
      MEL_START: return i == 2'd0 ? DO : i == 2'd1 ? MI : SO;
      MEL_EAT:   return i == 2'd0 ? MI : SO;
      default:   return i == 2'd0 ? SO : i == 2'd1 ? MI : DO;
    endcase
  endfunction
  function automatic logic [3:0] note_len(input logic [1:0] m, input logic [1:0] i);
    return m == MEL_START ? 4'd3 : m == MEL_EAT ? 4'd2 : i == 2'd2 ? 4'd8 : 4'd4;
  endfunction
  function automatic logic [1:0] last_idx(input logic [1:0] m);
    return m == MEL_EAT ? 2'd1 : 2'd2;
  endfunction
  assign sel  = crash_evt ? MEL_CRASH : start_evt ? MEL_START : MEL_EAT;
  // crash always (re)starts; start/eat only from idle
  assign go   = crash_evt || (state == IDLE && (start_evt || eat_evt));
  assign nidx = idx + 2'd1;
  assign on   = state == PLAY && !mute;
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      mel         <= MEL_START;
      idx         <= '0;
      dur         <= '0;
      tick        <= '0;
      freq_datas  <= '0;
      output_beep <= 1'b0;
      busy        <= 1'b0;
    end else if (go) begin
      state       <= PLAY;
      mel         <= sel;
      idx         <= 2'd0;
      dur         <= note_len(sel, 2'd0);
      tick        <= '0;
      busy        <= 1'b1;
      output_beep <= !mute;
      freq_datas  <= mute ? '0 : note_val(sel, 2'd0);
    end else if (state != IDLE) begin
      tick        <= tick == TICK_MAX ? '0 : tick + 25'd1;
      output_beep <= on;
      freq_datas  <= on ? note_val(mel, idx) : '0;
      if (tick != TICK_MAX) begin
      end else if (state == PLAY && dur != 4'd1) begin
        dur <= dur - 4'd1;
      end else if (state == PLAY && idx == last_idx(mel)) begin
        state       <= IDLE;
        idx         <= '0;
        dur         <= '0;
        busy        <= 1'b0;
        output_beep <= 1'b0;
        freq_datas  <= '0;
`ifdef SOUND_GAP_EN
      end else if (state == PLAY) begin
        state       <= GAP;
        output_beep <= 1'b0;
        freq_datas  <= '0;
`endif
      end else begin
        state       <= PLAY;
        idx         <= nidx;
        dur         <= note_len(mel, nidx);
        output_beep <= !mute;
        freq_datas  <= mute ? '0 : note_val(mel, nidx);
      end
    end
  end
endmodule

// File: tb/tb_snake_sound_seq.sv
// tb_snake_sound_seq: directed checks of the sound sequencer melodies, priority, preemption, mute and reset
module tb_snake_sound_seq;
  localparam logic [17:0] F_DO = 18'd190839, F_MI = 18'd151514, F_SO = 18'd127550;
`ifdef SOUND_GAP_EN
  localparam int GAP = 5;
`else
  localparam int GAP = 0;
`endif
  logic sys_clk = 1'b0, sys_rst_n = 1'b0;
  logic start_evt = 1'b0, eat_evt = 1'b0, crash_evt = 1'b0, mute = 1'b0;
  logic [17:0] freq_datas;
  logic output_beep, busy;
  int n_chk = 0, n_pass = 0;
  snake_sound_seq #(.TICK_MAX(25'd4)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start_evt(start_evt), .eat_evt(eat_evt),
    .crash_evt(crash_evt), .mute(mute), .freq_datas(freq_datas), .output_beep(output_beep), .busy(busy)
  );
  always #5 sys_clk = ~sys_clk;
  task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: {busy,beep,freq} got %h expected %h", tag, got, exp);
  endtask
  task automatic run(input string tag, input logic b, input logic e, input logic [17:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      check(tag, {busy, output_beep, freq_datas}, {b, e, f});
      @(negedge sys_clk);
    end
  endtask
  task automatic pulse(input logic c, input logic s, input logic e);
    {crash_evt, start_evt, eat_evt} = {c, s, e};
    @(negedge sys_clk);
    {crash_evt, start_evt, eat_evt} = 3'b000;
  endtask
  initial begin
    #2;
    check("reset", {busy, output_beep, freq_datas}, 20'h0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    run("idle0", 0, 0, 0, 2);
    pulse(0, 0, 1);
    run("eat_mi", 1, 1, F_MI, 10);
    run("eat_gap", 1, 0, 0, GAP);
    run("eat_so", 1, 1, F_SO, 10);
    run("eat_end", 0, 0, 0, 3);
    pulse(0, 1, 1);
    run("pri_do", 1, 1, F_DO, 15);
    run("pri_gap1", 1, 0, 0, GAP);
    run("pri_mi", 1, 1, F_MI, 5);
    pulse(0, 0, 1);
    run("ign_mi", 1, 1, F_MI, 9);
    run("pri_gap2", 1, 0, 0, GAP);
    run("pri_so", 1, 1, F_SO, 15);
    run("pri_end", 0, 0, 0, 3);
    pulse(0, 0, 1);
    run("pre_mi", 1, 1, F_MI, 3);
    pulse(1, 0, 0);
    run("crash_so", 1, 1, F_SO, 20);
    run("crash_gap1", 1, 0, 0, GAP);
    run("crash_mi", 1, 1, F_MI, 20);
    run("crash_gap2", 1, 0, 0, GAP);
    run("crash_do", 1, 1, F_DO, 40);
    run("crash_end", 0, 0, 0, 3);
    mute = 1'b1;
    run("mute_idle", 0, 0, 0, 2);
    pulse(0, 1, 0);
    run("mute_start", 1, 0, 0, 45 + 2 * GAP);
    run("mute_end", 0, 0, 0, 2);
    mute = 1'b0;
    run("unmute_idle", 0, 0, 0, 2);
    pulse(0, 0, 1);
    run("mt_mi", 1, 1, F_MI, 2);
    mute = 1'b1;
    run("mt_lat_on", 1, 1, F_MI, 1);
    run("mt_quiet", 1, 0, 0, 6);
    mute = 1'b0;
    run("mt_lat_off", 1, 0, 0, 1);
    run("mt_gap", 1, 0, 0, GAP);
    run("mt_so", 1, 1, F_SO, 10);
    run("mt_end", 0, 0, 0, 2);
    pulse(0, 0, 1);
    run("rst_mi", 1, 1, F_MI, 10);
    run("rst_gap", 1, 0, 0, GAP);
    run("rst_so", 1, 1, F_SO, 3);
    #2 sys_rst_n = 1'b0;
    #1 check("rst_async", {busy, output_beep, freq_datas}, 20'h0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    run("rst_after", 0, 0, 0, 30);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
